qpu_exu_cwbck_arb: RTL and testbench

- Arbitrates the single classical-register-file (CRF) write port between two requesters: the ALU classical writeback (cwbck) and the long-pipe LSU load writeback.
- Presents one registered writeback stream to the CRF with a valid/ready handshake.
- Long-pipe results have priority because they are older. A wait counter forces an ALU grant after MAX_WAIT blocked cycles.
- Sits between QPU_exu_alu / LSU response path and the CRF write port in the EXU.

---
 rtl/qpu_exu_cwbck_arb_pkg.sv | 15 +
 rtl/qpu_wbck_slot.sv | 60 ++++++
 rtl/qpu_exu_cwbck_arb.sv | 137 +++++++++++++
 tb/tb_qpu_exu_cwbck_arb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qpu_exu_cwbck_arb_pkg.sv
// Shared types and constants for the CRF writeback arbiter.
package qpu_exu_cwbck_arb_pkg;

  typedef enum logic {
    PriLsu   = 1'b0,
    ForceAlu = 1'b1
  } arb_state_e;

  localparam logic WbckSrcAlu = 1'b0;
  localparam logic WbckSrcLsu = 1'b1;

  localparam int unsigned MaxWaitDefault = 4;
  localparam int unsigned WaitCntW       = 4;

endpackage

// File: rtl/qpu_wbck_slot.sv
// Single-entry valid/ready output register; a load may coincide with the drain of the held entry.
module qpu_wbck_slot #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RFIDX_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [XLEN-1:0]    data_i,
  input  logic [RFIDX_W-1:0] rdidx_i,
  input  logic               src_i,
  output logic               free_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [XLEN-1:0]    out_data_o,
  output logic [RFIDX_W-1:0] out_rdidx_o,
  output logic               out_src_o
);

  logic               valid_q, valid_d;
  logic [XLEN-1:0]    data_q, data_d;
  logic [RFIDX_W-1:0] rdidx_q, rdidx_d;
  logic               src_q, src_d;

  always_comb begin
    free_o  = !valid_q || out_ready_i;
    valid_d = valid_q;
    data_d  = data_q;
    rdidx_d = rdidx_q;
    src_d   = src_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      rdidx_d = rdidx_i;
      src_d   = src_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      rdidx_q <= '0;
      src_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      rdidx_q <= rdidx_d;
      src_q   <= src_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_rdidx_o = rdidx_q;
  assign out_src_o   = src_q;

endmodule

// File: rtl/qpu_exu_cwbck_arb.sv
// CRF write-port arbiter: LSU has priority, ALU is force-granted after MAX_WAIT blocked cycles.
// Optional stall counters are built when QPU_CWBCK_ARB_PERF_EN is defined.
module qpu_exu_cwbck_arb
  import qpu_exu_cwbck_arb_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RFIDX_W  = 5,
  parameter int unsigned MAX_WAIT = MaxWaitDefault
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_wbck_i_valid,
  output logic               alu_wbck_i_ready,
  input  logic [XLEN-1:0]    alu_wbck_i_data,
  input  logic [RFIDX_W-1:0] alu_wbck_i_rdidx,
  input  logic               lsu_wbck_i_valid,
  output logic               lsu_wbck_i_ready,
  input  logic [XLEN-1:0]    lsu_wbck_i_data,
  input  logic [RFIDX_W-1:0] lsu_wbck_i_rdidx,
  output logic               crf_wbck_o_valid,
  input  logic               crf_wbck_o_ready,
  output logic [XLEN-1:0]    crf_wbck_o_data,
  output logic [RFIDX_W-1:0] crf_wbck_o_rdidx,
  output logic               crf_wbck_o_src
`ifdef QPU_CWBCK_ARB_PERF_EN
  ,
  input  logic               perf_clr,
  output logic [15:0]        perf_alu_stall_cnt,
  output logic [15:0]        perf_lsu_stall_cnt
`endif
);

  localparam logic [WaitCntW-1:0] MaxWaitCnt = WaitCntW'(MAX_WAIT);

  arb_state_e            state_q, state_d;
  logic [WaitCntW-1:0]   wait_cnt_q, wait_cnt_d;
  logic                  slot_free, grant_alu, grant_lsu;
  logic                  load;
  logic [XLEN-1:0]       load_data;
  logic [RFIDX_W-1:0]    load_rdidx;
  logic                  load_src;

  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (slot_free) begin
      if (state_q == ForceAlu) begin
        grant_alu = alu_wbck_i_valid;
        grant_lsu = !alu_wbck_i_valid && lsu_wbck_i_valid;
      end else begin
        grant_lsu = lsu_wbck_i_valid;
        grant_alu = !lsu_wbck_i_valid && alu_wbck_i_valid;
      end
    end
    load_data  = grant_alu ? alu_wbck_i_data : lsu_wbck_i_data;
    load_rdidx = grant_alu ? alu_wbck_i_rdidx : lsu_wbck_i_rdidx;
    load_src   = grant_alu ? WbckSrcAlu : WbckSrcLsu;
    // x0 writes are acknowledged but never occupy the slot
    load       = (grant_alu || grant_lsu) && (load_rdidx != '0);
  end

  assign alu_wbck_i_ready = grant_alu;
  assign lsu_wbck_i_ready = grant_lsu;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!alu_wbck_i_valid || grant_alu) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < MaxWaitCnt) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    state_d = state_q;
    unique case (state_q)
      PriLsu:   if (wait_cnt_d == MaxWaitCnt) state_d = ForceAlu;
      ForceAlu: if (grant_alu) state_d = PriLsu;
      default:  state_d = PriLsu;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PriLsu;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  qpu_wbck_slot #(
    .XLEN   (XLEN),
    .RFIDX_W(RFIDX_W)
  ) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .data_i     (load_data),
    .rdidx_i    (load_rdidx),
    .src_i      (load_src),
    .free_o     (slot_free),
    .out_valid_o(crf_wbck_o_valid),
    .out_ready_i(crf_wbck_o_ready),
    .out_data_o (crf_wbck_o_data),
    .out_rdidx_o(crf_wbck_o_rdidx),
    .out_src_o  (crf_wbck_o_src)
  );

`ifdef QPU_CWBCK_ARB_PERF_EN
  logic [15:0] perf_alu_q, perf_alu_d, perf_lsu_q, perf_lsu_d;

  always_comb begin
    perf_alu_d = perf_alu_q;
    perf_lsu_d = perf_lsu_q;
    if (perf_clr) begin
      perf_alu_d = '0;
      perf_lsu_d = '0;
    end else begin
      if (alu_wbck_i_valid && !grant_alu && perf_alu_q != 16'hFFFF) perf_alu_d = perf_alu_q + 1'b1;
      if (lsu_wbck_i_valid && !grant_lsu && perf_lsu_q != 16'hFFFF) perf_lsu_d = perf_lsu_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_alu_q <= '0;
      perf_lsu_q <= '0;
    end else begin
      perf_alu_q <= perf_alu_d;
      perf_lsu_q <= perf_lsu_d;
    end
  end

  assign perf_alu_stall_cnt = perf_alu_q;
  assign perf_lsu_stall_cnt = perf_lsu_q;
`endif

endmodule

// File: tb/tb_qpu_exu_cwbck_arb.sv
// Bench for qpu_exu_cwbck_arb: directed vector table, async-reset sequence, randomized model check.
module tb_qpu_exu_cwbck_arb;
  import qpu_exu_cwbck_arb_pkg::*;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned RFIDX_W  = 5;
  localparam int unsigned MAX_WAIT = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [XLEN-1:0]    alu_data, lsu_data, crf_data;
  logic [RFIDX_W-1:0] alu_rdidx, lsu_rdidx, crf_rdidx;
  logic               crf_valid, crf_ready, crf_src;
`ifdef QPU_CWBCK_ARB_PERF_EN
  logic               perf_clr = 1'b0;
  logic [15:0]        perf_alu, perf_lsu;
`endif

  always #5 clk = ~clk;

  qpu_exu_cwbck_arb #(
    .XLEN    (XLEN),
    .RFIDX_W (RFIDX_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alu_wbck_i_valid(alu_valid),
    .alu_wbck_i_ready(alu_ready),
    .alu_wbck_i_data (alu_data),
    .alu_wbck_i_rdidx(alu_rdidx),
    .lsu_wbck_i_valid(lsu_valid),
    .lsu_wbck_i_ready(lsu_ready),
    .lsu_wbck_i_data (lsu_data),
    .lsu_wbck_i_rdidx(lsu_rdidx),
    .crf_wbck_o_valid(crf_valid),
    .crf_wbck_o_ready(crf_ready),
    .crf_wbck_o_data (crf_data),
    .crf_wbck_o_rdidx(crf_rdidx),
    .crf_wbck_o_src  (crf_src)
`ifdef QPU_CWBCK_ARB_PERF_EN
    ,
    .perf_clr          (perf_clr),
    .perf_alu_stall_cnt(perf_alu),
    .perf_lsu_stall_cnt(perf_lsu)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        av; logic [31:0] ad; logic [4:0] ai;
    logic        lv; logic [31:0] ld; logic [4:0] li;
    logic        cr;
    logic        e_ar; logic e_lr;
    logic        e_ov; logic [31:0] e_od; logic [4:0] e_oi; logic e_os;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic [31:0] ad, input logic [4:0] ai,
                              input logic lv, input logic [31:0] ld, input logic [4:0] li,
                              input logic cr, input logic e_ar, input logic e_lr,
                              input logic e_ov, input logic [31:0] e_od, input logic [4:0] e_oi,
                              input logic e_os);
    vec_t v;
    v.av = av; v.ad = ad; v.ai = ai; v.lv = lv; v.ld = ld; v.li = li; v.cr = cr;
    v.e_ar = e_ar; v.e_lr = e_lr; v.e_ov = e_ov; v.e_od = e_od; v.e_oi = e_oi; v.e_os = e_os;
    return v;
  endfunction

  // Reference model: the output slot plus how long the ALU has been starved and whether it is owed a turn.
  bit          m_ov;
  logic [31:0] m_od;
  logic [4:0]  m_oi;
  bit          m_os;
  int          m_blocked;
  bit          m_owed;

  task automatic model_reset();
    m_ov = 0; m_od = '0; m_oi = '0; m_os = 0; m_blocked = 0; m_owed = 0;
  endtask

  task automatic model_grant(output bit ga, output bit gl);
    bit free;
    free = !m_ov || crf_ready;
    ga = 0; gl = 0;
    if (free) begin
      if (m_owed) begin ga = alu_valid; gl = !alu_valid && lsu_valid; end
      else        begin gl = lsu_valid; ga = !lsu_valid && alu_valid; end
    end
  endtask

  task automatic model_clock(input bit ga, input bit gl);
    if (ga && alu_rdidx != 0) begin
      m_ov = 1; m_od = alu_data; m_oi = alu_rdidx; m_os = 0;
    end else if (gl && lsu_rdidx != 0) begin
      m_ov = 1; m_od = lsu_data; m_oi = lsu_rdidx; m_os = 1;
    end else if (crf_ready) begin
      m_ov = 0;
    end
    if (!alu_valid || ga) m_blocked = 0;
    else if (m_blocked < MAX_WAIT) m_blocked++;
    if (ga) m_owed = 0;
    else if (m_blocked == MAX_WAIT) m_owed = 1;
  endtask

  task automatic drive(input logic av, input logic [31:0] ad, input logic [4:0] ai,
                       input logic lv, input logic [31:0] ld, input logic [4:0] li,
                       input logic cr);
    alu_valid = av; alu_data = ad; alu_rdidx = ai;
    lsu_valid = lv; lsu_data = ld; lsu_rdidx = li;
    crf_ready = cr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    bit   ga, gl;
    bit   alu_pend, lsu_pend;

    vecs.push_back(mk(1, 'h1234, 3, 0, 0, 0, 1, 1, 0, 1, 'h1234, 3, 0));
    vecs.push_back(mk(1, 'h55, 5, 1, 'h66, 6, 1, 0, 1, 1, 'h66, 6, 1));
    vecs.push_back(mk(1, 'h55, 5, 0, 0, 0, 1, 1, 0, 1, 'h55, 5, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h55, 5, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1, 'h77, 7, 1, 'h80 + k, 5'(16 + k), 1, 0, 1, 1, 'h80 + k, 5'(16 + k), 1));
    vecs.push_back(mk(1, 'h77, 7, 1, 'h90, 20, 1, 1, 0, 1, 'h77, 7, 0));
    vecs.push_back(mk(0, 0, 0, 1, 'h90, 20, 1, 0, 1, 1, 'h90, 20, 1));
    vecs.push_back(mk(0, 0, 0, 1, 'hAA, 10, 1, 0, 1, 1, 'hAA, 10, 1));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 'hBB, 11, 1, 'hCC, 13, 0, 0, 0, 1, 'hAA, 10, 1));
    vecs.push_back(mk(1, 'hBB, 11, 1, 'hCC, 13, 1, 0, 1, 1, 'hCC, 13, 1));
    vecs.push_back(mk(1, 'hBB, 11, 1, 'hDD, 14, 1, 1, 0, 1, 'hBB, 11, 0));
    vecs.push_back(mk(1, 'hEE, 0, 1, 'hDD, 14, 1, 0, 1, 1, 'hDD, 14, 1));
    vecs.push_back(mk(1, 'hEE, 0, 0, 0, 0, 1, 1, 0, 0, 'hDD, 14, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'hDD, 14, 1));

    drive(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    #1;
    chk("rst_valid", crf_valid, 0);
    chk("rst_data", crf_data, 0);
    chk("rst_rdidx", crf_rdidx, 0);
    chk("rst_src", crf_src, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_lsu_ready", lsu_ready, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].av, vecs[i].ad, vecs[i].ai, vecs[i].lv, vecs[i].ld, vecs[i].li, vecs[i].cr);
      #1;
      chk($sformatf("vec%0d_alu_ready", i), alu_ready, vecs[i].e_ar);
      chk($sformatf("vec%0d_lsu_ready", i), lsu_ready, vecs[i].e_lr);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_crf_valid", i), crf_valid, vecs[i].e_ov);
      chk($sformatf("vec%0d_crf_data", i), crf_data, vecs[i].e_od);
      chk($sformatf("vec%0d_crf_rdidx", i), crf_rdidx, vecs[i].e_oi);
      chk($sformatf("vec%0d_crf_src", i), crf_src, vecs[i].e_os);
    end

    // Starve the ALU into the forced state with a held entry, then reset asynchronously.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1, 'h31, 9, 1, 'h40 + k, 5'(24 + k), 1);
      #1;
      chk("starve_lsu_ready", lsu_ready, 1);
      chk("starve_alu_ready", alu_ready, 0);
    end
    @(negedge clk);
    drive(1, 'h31, 9, 1, 'h50, 30, 0);
    #1;
    chk("pre_rst_crf_valid", crf_valid, 1);
    chk("pre_rst_state", dut.state_q, ForceAlu);
    rst_n = 1'b0;
    #1;
    chk("async_rst_crf_valid", crf_valid, 0);
    chk("async_rst_state", dut.state_q, PriLsu);
    chk("async_rst_wait_cnt", dut.wait_cnt_q, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 'h31, 9, 1, 'h50, 30, 1);
    #1;
    chk("post_rst_lsu_ready", lsu_ready, 1);
    chk("post_rst_alu_ready", alu_ready, 0);

    // Randomized traffic; requesters hold their payload until accepted.
    do_reset();
    alu_pend = 0;
    lsu_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!alu_pend && ($urandom_range(0, 2) != 0)) begin
        alu_pend  = 1;
        alu_data  = $urandom;
        alu_rdidx = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      end
      if (!lsu_pend && ($urandom_range(0, 2) != 0)) begin
        lsu_pend  = 1;
        lsu_data  = $urandom;
        lsu_rdidx = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      end
      alu_valid = alu_pend;
      lsu_valid = lsu_pend;
      crf_ready = ($urandom_range(0, 3) != 0);
      #1;
      model_grant(ga, gl);
      chk("rnd_alu_ready", alu_ready, ga);
      chk("rnd_lsu_ready", lsu_ready, gl);
      chk("rnd_crf_valid", crf_valid, m_ov);
      if (m_ov) begin
        chk("rnd_crf_data", crf_data, m_od);
        chk("rnd_crf_rdidx", crf_rdidx, m_oi);
        chk("rnd_crf_src", crf_src, m_os);
      end
      model_clock(ga, gl);
      if (ga) alu_pend = 0;
      if (gl) lsu_pend = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
